ingress_stats_arbiter: RTL and testbench

Collects per-frame statistics from `N_PORTS` ingress frame processors and maintains the per-port Ethernet statistics counter bank. A single shared update engine serves all ports. A round-robin arbiter grants one pending port per update slot. A host read port exposes any counter.

---
 rtl/ethernet_stats_pkg.sv | 18 +
 rtl/ingress_stats_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_ingress_stats_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ethernet_stats_pkg.sv
// Shared Ethernet statistics definitions.
//   FRAME_SIZE_BIT_WIDTH : width of the per-frame byte count reported by a frame processor.
//   ether_stats_vector   : per-frame classification flags produced at end of frame.
package ethernet_stats_pkg;

  parameter int unsigned FRAME_SIZE_BIT_WIDTH = 14;

  typedef struct packed {
    logic valid_frame;
    logic bad_crc;
    logic under_size;
    logic over_size;
    logic broadcast;
    logic multicast;
    logic unicast;
  } ether_stats_vector;

endpackage

// File: rtl/ingress_stats_arbiter.sv
// Per-port Ethernet statistics counter bank fed by N_PORTS ingress frame processors.
// One shared update engine, round-robin granted, applies all 8 counter increments of a
// port in a single cycle. A host read port returns any counter one cycle after the request.
//
// Ports:
//   lcl_clk, reset      clock and synchronous active-high reset
//   iv_stats_valid      per-port stats valid level (rising edge = new frame stats)
//   iv_frame_size       per-port frame size, port p at [p*FSW +: FSW]
//   iv_stats_vector     per-port flag vector
//   i_clear             zero all counters (single-cycle pulse)
//   i_rd_req            host read strobe; iv_rd_port / iv_rd_sel select the counter
//   o_rd_valid          one-cycle read data valid, ov_rd_data carries the value
//   ov_overflow         one-cycle pulse per port when a stats event is dropped
//   o_busy              any port pending or an update in flight
module ingress_stats_arbiter
  import ethernet_stats_pkg::*;
#(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned FSW       = FRAME_SIZE_BIT_WIDTH,
  localparam int unsigned PW       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                              lcl_clk,
  input  logic                              reset,
  input  logic              [N_PORTS-1:0]   iv_stats_valid,
  input  logic              [N_PORTS*FSW-1:0] iv_frame_size,
  input  ether_stats_vector [N_PORTS-1:0]   iv_stats_vector,
  input  logic                              i_clear,
  input  logic                              i_rd_req,
  input  logic              [PW-1:0]        iv_rd_port,
  input  logic              [2:0]           iv_rd_sel,
  output logic                              o_rd_valid,
  output logic              [CNT_WIDTH-1:0] ov_rd_data,
  output logic              [N_PORTS-1:0]   ov_overflow,
  output logic                              o_busy
);

  localparam int unsigned NCNT = 8;
  // Adder width wide enough that neither operand can overflow it before saturation.
  localparam int unsigned SW = ((CNT_WIDTH > FSW) ? CNT_WIDTH : FSW) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ArbSt,
    UpdateSt
  } state_e;

  state_e state_q, state_d;

  logic [N_PORTS-1:0] valid_hist_q;
  logic [N_PORTS-1:0] armed_q;
  logic [N_PORTS-1:0] rise;
  logic [N_PORTS-1:0] pending_q, pending_d;
  logic [N_PORTS-1:0] accept, drop;
  logic [N_PORTS-1:0] overflow_q;

  logic              [FSW-1:0] slot_size_q [N_PORTS];
  ether_stats_vector           slot_vec_q  [N_PORTS];

  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              grant_valid;
  logic [PW-1:0]     grant_idx;
  int unsigned       cand;

  logic [PW-1:0]     work_port_q;
  logic [FSW-1:0]    work_size_q;
  ether_stats_vector work_vec_q;
  logic [NCNT-1:0]   work_flags;

  logic [CNT_WIDTH-1:0] cnt_q [N_PORTS][NCNT];
  logic [CNT_WIDTH-1:0] cnt_d [N_PORTS][NCNT];

  logic                 rd_valid_q;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_value;
  logic                 busy_q;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [FSW-1:0] b);
    logic [SW-1:0]        sum;
    logic [CNT_WIDTH-1:0] res;
    sum = SW'(a) + SW'(b);
    if (sum > SW'(CNT_MAX)) res = CNT_MAX;
    else res = sum[CNT_WIDTH-1:0];
    return res;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] a);
    return (a == CNT_MAX) ? a : a + 1'b1;
  endfunction

  // A port only counts edges once it has been seen low since reset, so a level held high
  // through reset is not mistaken for a fresh frame.
  assign rise = iv_stats_valid & ~valid_hist_q & armed_q;

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (state_q == ArbSt) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        cand = (32'(rr_ptr_q) + i) % N_PORTS;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
          if (!grant_valid && p == cand && pending_q[p]) begin
            grant_valid = 1'b1;
            grant_idx   = PW'(p);
          end
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ArbSt: begin
        if (grant_valid) begin
          state_d  = UpdateSt;
          rr_ptr_d = (grant_idx == PW'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      UpdateSt: state_d = ArbSt;
      default:  state_d = ArbSt;
    endcase
  end

  // Grant clears first so an edge on the port being granted is accepted, not dropped.
  always_comb begin
    pending_d = pending_q;
    accept    = '0;
    drop      = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (grant_valid && grant_idx == PW'(p)) pending_d[p] = 1'b0;
      if (rise[p]) begin
        if (pending_d[p]) begin
          drop[p] = 1'b1;
        end else begin
          accept[p]    = 1'b1;
          pending_d[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge lcl_clk) begin
    if (reset) begin
      valid_hist_q <= '0;
      armed_q      <= ~iv_stats_valid;
      pending_q    <= '0;
      overflow_q   <= '0;
      state_q      <= ArbSt;
      rr_ptr_q     <= '0;
      work_port_q  <= '0;
      work_size_q  <= '0;
      work_vec_q   <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        slot_size_q[p] <= '0;
        slot_vec_q[p]  <= '0;
      end
    end else begin
      valid_hist_q <= iv_stats_valid;
      armed_q      <= armed_q | ~iv_stats_valid;
      pending_q    <= pending_d;
      overflow_q   <= drop;
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      for (int p = 0; p < N_PORTS; p++) begin
        if (accept[p]) begin
          slot_size_q[p] <= iv_frame_size[p*FSW +: FSW];
          slot_vec_q[p]  <= iv_stats_vector[p];
        end
        // Work registers take the slot contents before any same-cycle re-capture.
        if (grant_valid && grant_idx == PW'(p)) begin
          work_port_q <= PW'(p);
          work_size_q <= slot_size_q[p];
          work_vec_q  <= slot_vec_q[p];
        end
      end
    end
  end

  // Bit i is the flag feeding counter index i; index 0 is the octet counter.
  assign work_flags = {work_vec_q.unicast, work_vec_q.multicast, work_vec_q.broadcast,
                       work_vec_q.over_size, work_vec_q.under_size, work_vec_q.bad_crc,
                       work_vec_q.valid_frame, 1'b0};

  // Clear wins over a concurrent update.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      for (int p = 0; p < N_PORTS; p++) begin
        for (int c = 0; c < NCNT; c++) cnt_d[p][c] = '0;
      end
    end else if (state_q == UpdateSt) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (PW'(p) == work_port_q) begin
          cnt_d[p][0] = sat_add(cnt_q[p][0], work_size_q);
          for (int c = 1; c < NCNT; c++) begin
            if (work_flags[c]) cnt_d[p][c] = sat_inc(cnt_q[p][c]);
          end
        end
      end
    end
  end

  always_ff @(posedge lcl_clk) begin
    if (reset) begin
      for (int p = 0; p < N_PORTS; p++) begin
        for (int c = 0; c < NCNT; c++) cnt_q[p][c] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Reads see the registered bank, so a same-cycle update is not yet visible.
  // A port index with no matching counter returns 0.
  always_comb begin
    rd_value = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      for (int c = 0; c < NCNT; c++) begin
        if (PW'(p) == iv_rd_port && 3'(c) == iv_rd_sel) rd_value = cnt_q[p][c];
      end
    end
  end

  always_ff @(posedge lcl_clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      rd_valid_q <= i_rd_req;
      if (i_rd_req) rd_data_q <= rd_value;
      busy_q     <= (|pending_q) | (state_q == UpdateSt);
    end
  end

  assign o_rd_valid  = rd_valid_q;
  assign ov_rd_data  = rd_data_q;
  assign ov_overflow = overflow_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_ingress_stats_arbiter.sv
// Directed bench for ingress_stats_arbiter: a default build (4 ports, 32-bit counters) and
// an 8-bit-counter build for saturation.
module tb_ingress_stats_arbiter;
  import ethernet_stats_pkg::*;

  localparam int FSW = FRAME_SIZE_BIT_WIDTH;
  localparam logic [6:0] VF  = 7'b1000000;
  localparam logic [6:0] CRC = 7'b0100000;
  localparam logic [6:0] US  = 7'b0010000;
  localparam logic [6:0] OS  = 7'b0001000;
  localparam logic [6:0] BC  = 7'b0000100;
  localparam logic [6:0] MC  = 7'b0000010;
  localparam logic [6:0] UC  = 7'b0000001;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [3:0]                valid;
  logic [4*FSW-1:0]          fsize;
  ether_stats_vector [3:0]   svec;
  logic                      clear, rd_req;
  logic [1:0]                rd_port;
  logic [2:0]                rd_sel;
  logic                      rd_valid;
  logic [31:0]               rd_data;
  logic [3:0]                ov;
  logic                      busy;

  logic [3:0]                s_valid;
  logic [4*FSW-1:0]          s_fsize;
  ether_stats_vector [3:0]   s_svec;
  logic                      s_clear, s_rd_req;
  logic [1:0]                s_rd_port;
  logic [2:0]                s_rd_sel;
  logic                      s_rd_valid;
  logic [7:0]                s_rd_data;
  logic [3:0]                s_ov;
  logic                      s_busy;

  int total = 0;
  int bad = 0;
  logic [31:0] d;
  logic        v;
  logic [7:0]  sd;
  logic        sv;

  always #5 clk = ~clk;

  ingress_stats_arbiter #(.N_PORTS(4), .CNT_WIDTH(32)) dut (
    .lcl_clk(clk), .reset(reset), .iv_stats_valid(valid), .iv_frame_size(fsize),
    .iv_stats_vector(svec), .i_clear(clear), .i_rd_req(rd_req), .iv_rd_port(rd_port),
    .iv_rd_sel(rd_sel), .o_rd_valid(rd_valid), .ov_rd_data(rd_data), .ov_overflow(ov),
    .o_busy(busy)
  );

  ingress_stats_arbiter #(.N_PORTS(4), .CNT_WIDTH(8)) dut_sat (
    .lcl_clk(clk), .reset(reset), .iv_stats_valid(s_valid), .iv_frame_size(s_fsize),
    .iv_stats_vector(s_svec), .i_clear(s_clear), .i_rd_req(s_rd_req), .iv_rd_port(s_rd_port),
    .iv_rd_sel(s_rd_sel), .o_rd_valid(s_rd_valid), .ov_rd_data(s_rd_data), .ov_overflow(s_ov),
    .o_busy(s_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    valid = '0; clear = 1'b0; rd_req = 1'b0;
    s_valid = '0; s_clear = 1'b0; s_rd_req = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic set_port(input int p, input int size, input logic [6:0] flags);
    fsize[p*FSW +: FSW] = FSW'(size);
    svec[p] = ether_stats_vector'(flags);
  endtask

  task automatic rd(input int p, input int c, output logic [31:0] data, output logic vld);
    rd_port = 2'(p);
    rd_sel  = 3'(c);
    rd_req  = 1'b1;
    tick();
    data   = rd_data;
    vld    = rd_valid;
    rd_req = 1'b0;
  endtask

  task automatic s_rd(input int c, output logic [7:0] data, output logic vld);
    s_rd_port = 2'd0;
    s_rd_sel  = 3'(c);
    s_rd_req  = 1'b1;
    tick();
    data     = s_rd_data;
    vld      = s_rd_valid;
    s_rd_req = 1'b0;
  endtask

  task automatic s_event(input int size, input logic [6:0] flags);
    s_fsize[0 +: FSW] = FSW'(size);
    s_svec[0] = ether_stats_vector'(flags);
    s_valid[0] = 1'b1;
    tick();
    s_valid[0] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
    total++; if (ov !== 4'd0) begin bad++; $display("FAIL reset_overflow got %b want 0000", ov); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    rd(0, 0, d, v);
    total++; if (v !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL reset_read got v=%b d=%0d want v=1 d=0", v, d); end
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_pulse got %b want 0", rd_valid); end
  endtask

  task automatic test_single_frame();
    logic [31:0] exp [8] = '{64, 1, 0, 0, 0, 0, 0, 1};
    apply_reset();
    set_port(0, 64, VF | UC);
    valid[0] = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_early got %b want 0", busy); end
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got %b want 1", busy); end
    tick();
    for (int c = 0; c < 8; c++) begin
      rd(0, c, d, v);
      total++;
      if (v !== 1'b1 || d !== exp[c]) begin
        bad++; $display("FAIL single_p0_idx%0d got v=%b d=%0d want v=1 d=%0d", c, v, d, exp[c]);
      end
    end
    rd(1, 0, d, v);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL single_p1_octets got %0d want 0", d); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle got %b want 0", busy); end
    valid[0] = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int          rp [7] = '{0, 1, 1, 2, 2, 3, 3};
    logic [31:0] re [7] = '{64, 0, 65, 0, 66, 0, 67};
    logic [7:0]  mask [4] = '{8'b0000_0010, 8'b0000_0100, 8'b0010_1000, 8'b0101_0000};
    apply_reset();
    set_port(0, 64, VF);
    set_port(1, 65, CRC);
    set_port(2, 66, US | BC);
    set_port(3, 67, OS | MC);
    valid = 4'hF;
    repeat (3) tick();
    // Back-to-back reads, one per cycle, tracking each port's update 2 cycles apart.
    for (int k = 0; k < 7; k++) begin
      rd(rp[k], 0, d, v);
      total++;
      if (v !== 1'b1 || d !== re[k]) begin
        bad++; $display("FAIL rr_step%0d_p%0d got v=%b d=%0d want v=1 d=%0d", k, rp[k], v, d, re[k]);
      end
    end
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rr_rd_valid_drop got %b want 0", rd_valid); end
    for (int p = 0; p < 4; p++) begin
      for (int c = 1; c < 8; c++) begin
        rd(p, c, d, v);
        total++;
        if (d !== 32'(mask[p][c])) begin
          bad++; $display("FAIL rr_flags_p%0d_idx%0d got %0d want %0d", p, c, d, mask[p][c]);
        end
      end
    end
    valid = '0;
    tick();
  endtask

  task automatic test_overflow();
    apply_reset();
    set_port(0, 50, VF);
    set_port(1, 60, VF);
    set_port(2, 100, VF);
    valid = 4'b0111;
    for (int c = 1; c <= 8; c++) begin
      tick();
      total++;
      if (ov !== ((c == 3) ? 4'b0100 : 4'b0000)) begin
        bad++; $display("FAIL ovf_cycle%0d got %b want %b", c, ov, (c == 3) ? 4'b0100 : 4'b0000);
      end
      if (c == 1) valid[2] = 1'b0;
      if (c == 2) begin
        set_port(2, 200, CRC);
        valid[2] = 1'b1;
      end
    end
    rd(2, 0, d, v);
    total++; if (d !== 32'd100) begin bad++; $display("FAIL ovf_p2_octets got %0d want 100", d); end
    rd(2, 2, d, v);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL ovf_p2_badcrc got %0d want 0", d); end
    rd(0, 0, d, v);
    total++; if (d !== 32'd50) begin bad++; $display("FAIL ovf_p0_octets got %0d want 50", d); end
    rd(1, 0, d, v);
    total++; if (d !== 32'd60) begin bad++; $display("FAIL ovf_p1_octets got %0d want 60", d); end
    repeat (3) tick();
    rd(2, 0, d, v);
    total++; if (d !== 32'd100) begin bad++; $display("FAIL ovf_p2_octets_late got %0d want 100", d); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_busy_idle got %b want 0", busy); end
    valid = '0;
    tick();
  endtask

  task automatic test_same_port_conflict();
    apply_reset();
    set_port(0, 10, VF);
    set_port(1, 30, VF);
    valid = 4'b0011;
    for (int c = 1; c <= 7; c++) begin
      tick();
      total++;
      if (ov !== 4'b0000) begin bad++; $display("FAIL conflict_ovf_cycle%0d got %b want 0000", c, ov); end
      if (c == 1) valid[1] = 1'b0;
      if (c == 3) begin
        set_port(1, 40, UC);
        valid[1] = 1'b1;
      end
    end
    rd(1, 0, d, v);
    total++; if (d !== 32'd70) begin bad++; $display("FAIL conflict_p1_octets got %0d want 70", d); end
    rd(1, 1, d, v);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL conflict_p1_valid got %0d want 1", d); end
    rd(1, 7, d, v);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL conflict_p1_unicast got %0d want 1", d); end
    rd(0, 0, d, v);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL conflict_p0_octets got %0d want 10", d); end
    valid = '0;
    tick();
  endtask

  task automatic test_clear_collision();
    apply_reset();
    set_port(0, 64, VF | UC);
    valid = 4'b0001;
    repeat (3) tick();
    rd(0, 0, d, v);
    total++; if (d !== 32'd64) begin bad++; $display("FAIL clr_pre_p0 got %0d want 64", d); end
    set_port(1, 90, VF);
    set_port(3, 120, VF);
    valid = 4'b1010;
    tick();
    tick();
    clear = 1'b1;  // lands on port 1's update cycle
    tick();
    clear = 1'b0;
    rd(1, 0, d, v);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clr_p1_octets got %0d want 0", d); end
    rd(0, 0, d, v);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clr_p0_octets got %0d want 0", d); end
    rd(3, 0, d, v);
    total++; if (d !== 32'd120) begin bad++; $display("FAIL clr_p3_octets got %0d want 120", d); end
    rd(3, 1, d, v);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL clr_p3_valid got %0d want 1", d); end
    rd(1, 1, d, v);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clr_p1_valid got %0d want 0", d); end
    rd(0, 7, d, v);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clr_p0_unicast got %0d want 0", d); end
    valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_port(3, 64, VF);
    valid = 4'b1000;
    repeat (3) tick();
    rd(3, 0, d, v);
    total++; if (d !== 32'd64) begin bad++; $display("FAIL rstmid_pre_p3 got %0d want 64", d); end
    valid = '0;
    tick();
    set_port(0, 11, VF);
    set_port(1, 22, VF);
    set_port(2, 33, VF);
    valid = 4'b0111;
    tick();
    reset = 1'b1;
    rd_req = 1'b1;
    rd_port = 2'd3;
    rd_sel = 3'd0;
    tick();
    rd_req = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    total++; if (ov !== 4'd0) begin bad++; $display("FAIL rstmid_ovf got %b want 0000", ov); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_rd_valid got %b want 0", rd_valid); end
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rstmid_rd_data got %0d want 0", rd_data); end
    tick();
    reset = 1'b0;
    repeat (8) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_after got %b want 0", busy); end
    for (int p = 0; p < 4; p++) begin
      rd(p, 0, d, v);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL rstmid_p%0d_octets got %0d want 0", p, d); end
    end
    valid[2] = 1'b0;
    tick();
    set_port(2, 77, VF);
    valid[2] = 1'b1;
    repeat (3) tick();
    rd(2, 0, d, v);
    total++; if (d !== 32'd77) begin bad++; $display("FAIL rstmid_p2_rearm got %0d want 77", d); end
    rd(0, 0, d, v);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rstmid_p0_held got %0d want 0", d); end
    valid = '0;
    tick();
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 254; k++) s_event(200, VF);
    s_rd(0, sd, sv);
    total++; if (sv !== 1'b1 || sd !== 8'd255) begin bad++; $display("FAIL sat_octets got v=%b d=%0d want v=1 d=255", sv, sd); end
    s_rd(1, sd, sv);
    total++; if (sd !== 8'd254) begin bad++; $display("FAIL sat_valid_254 got %0d want 254", sd); end
    s_event(200, VF);
    s_rd(1, sd, sv);
    total++; if (sd !== 8'd255) begin bad++; $display("FAIL sat_valid_255 got %0d want 255", sd); end
    s_event(200, VF);
    s_rd(1, sd, sv);
    total++; if (sd !== 8'd255) begin bad++; $display("FAIL sat_valid_hold got %0d want 255", sd); end
    s_rd(0, sd, sv);
    total++; if (sd !== 8'd255) begin bad++; $display("FAIL sat_octets_hold got %0d want 255", sd); end
    s_rd(2, sd, sv);
    total++; if (sd !== 8'd0) begin bad++; $display("FAIL sat_badcrc got %0d want 0", sd); end
  endtask

  initial begin
    valid = '0; fsize = '0; svec = '0; clear = 1'b0; rd_req = 1'b0; rd_port = '0; rd_sel = '0;
    s_valid = '0; s_fsize = '0; s_svec = '0; s_clear = 1'b0; s_rd_req = 1'b0;
    s_rd_port = '0; s_rd_sel = '0;
    apply_reset();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_overflow();
    test_same_port_conflict();
    test_clear_collision();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
